bcd_arith_seq: RTL and testbench

- Parametrised N-digit packed-BCD arithmetic unit with three operations: ADD, SUB and MUL.
- ADD and SUB complete in one clock. MUL is digit-serial and processes one multiplier digit per clock, so it takes N clocks.
- The block sits beside the decimal FPU datapath as the shared significand engine for decimal add, subtract and multiply. It uses a start/done handshake with a ready indicator.

---
 rtl/bcd_pkg.sv | 45 ++++
 rtl/bcd_mul_digit_n.sv | 34 +++
 rtl/bcd_arith_seq.sv | 166 ++++++++++++++++
 tb/tb_bcd_arith_seq.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and digit-level helpers for the packed-BCD arithmetic unit.
package bcd_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_SUB  = 2'd1,
        OP_MUL  = 2'd2,
        OP_RSVD = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ALU  = 2'd1,
        ST_MUL  = 2'd2
    } state_t;

    // A nibble is a legal BCD digit when it lies in 0..9.
    function automatic logic digitValid(input logic [3:0] d);
        return (d <= 4'd9);
    endfunction

    // Nine's complement of one digit; with a +1 carry-in it forms the ten's complement.
    function automatic logic [3:0] tensCompDigit(input logic [3:0] d);
        return 4'd9 - d;
    endfunction

    // One decimal digit add: returns {carry, digit}. Results for illegal digits are don't-care.
    function automatic logic [4:0] bcdDigitAdd(input logic [3:0] x, input logic [3:0] y,
                                               input logic c);
        logic [4:0] s;
        s = {1'b0, x} + {1'b0, y} + {4'b0000, c};
        if (s > 5'd9) begin
            return {1'b1, s[3:0] + 4'd6};
        end
        return {1'b0, s[3:0]};
    endfunction

    // Single-digit product table: returns {tens, ones} of x*y as two BCD digits.
    function automatic logic [7:0] digitMul(input logic [3:0] x, input logic [3:0] y);
        logic [6:0] p;
        p = 7'(x * y);
        return {4'(p / 7'd10), 4'(p % 7'd10)};
    endfunction

endpackage

// File: rtl/bcd_mul_digit_n.sv
// Combinational N-digit by 1-digit BCD multiplier producing an (N+1)-digit product.
module bcd_mul_digit_n
    import bcd_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [N*4-1:0]     a,
    input  logic [3:0]         d,
    output logic [(N+1)*4-1:0] p
);

    // Per-digit table products; each tens digit is folded into the next digit up with a decimal carry chain.
    always_comb begin
        logic [7:0] pp;
        logic [4:0] s;
        logic [3:0] hiPrev;
        logic       carry;
        p      = '0;
        pp     = '0;
        s      = '0;
        hiPrev = '0;
        carry  = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            pp           = digitMul(a[i*4 +: 4], d);
            s            = bcdDigitAdd(pp[3:0], hiPrev, carry);
            p[i*4 +: 4]  = s[3:0];
            carry        = s[4];
            hiPrev       = pp[7:4];
        end
        // Top digit never exceeds 9 for legal inputs (at most 8 + carry).
        p[N*4 +: 4] = hiPrev + {3'b000, carry};
    end

endmodule

// File: rtl/bcd_arith_seq.sv
// N-digit packed-BCD add/subtract (single cycle) and digit-serial multiply (N cycles).
module bcd_arith_seq
    import bcd_pkg::*;
#(
    parameter int N = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             ci,
    input  logic [N*4-1:0]   a,
    input  logic [N*4-1:0]   b,
    output logic [2*N*4-1:0] o,
    output logic             co,
    output logic             err,
    output logic             rdy,
    output logic             done
);

    localparam int W  = N * 4;
    localparam int RW = 2 * N * 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t                state;
    op_t                   opReg;
    logic [W-1:0]          aReg;
    logic [W-1:0]          bReg;
    logic                  ciReg;
    logic                  errReg;
    logic [CW-1:0]         cnt;
    logic [RW-1:0]         acc;

    logic                  inErr;
    logic [3:0]            mulDigit;
    logic [(N+1)*4-1:0]    partial;
    logic [RW-1:0]         addX;
    logic [RW-1:0]         addY;
    logic [RW-1:0]         addSum;
    logic                  addCin;
    logic                  carryN;

    assign rdy = (state == ST_IDLE);

    // Flag any non-decimal nibble on the operands presented with start.
    always_comb begin
        inErr = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!digitValid(a[i*4 +: 4]) || !digitValid(b[i*4 +: 4])) begin
                inErr = 1'b1;
            end
        end
    end

    // Select the multiplier digit addressed by the counter (most significant consumed first).
    always_comb begin
        mulDigit = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (cnt == CW'(i)) begin
                mulDigit = bReg[i*4 +: 4];
            end
        end
    end

    bcd_mul_digit_n #(.N(N)) uMulDigit (
        .a (aReg),
        .d (mulDigit),
        .p (partial)
    );

    // Operand mux for the shared adder: accumulate step in MUL, add/ten's-complement subtract otherwise.
    always_comb begin
        addX   = '0;
        addY   = '0;
        addCin = 1'b0;
        if (state == ST_MUL) begin
            addX                  = acc << 4;
            addY[(N+1)*4-1:0]     = partial;
        end else begin
            addX[W-1:0] = aReg;
            if (opReg == OP_SUB) begin
                // a - b - ci == a + (9's comp of b) + (1 - ci)
                for (int unsigned i = 0; i < N; i++) begin
                    addY[i*4 +: 4] = tensCompDigit(bReg[i*4 +: 4]);
                end
                addCin = ~ciReg;
            end else begin
                addY[W-1:0] = bReg;
                addCin      = ciReg;
            end
        end
    end

    // Shared 2N-digit decimal ripple adder; also taps the carry out of digit N-1.
    always_comb begin
        logic [4:0] s;
        logic       carry;
        addSum = '0;
        carryN = 1'b0;
        s      = '0;
        carry  = addCin;
        for (int unsigned i = 0; i < 2 * N; i++) begin
            s                = bcdDigitAdd(addX[i*4 +: 4], addY[i*4 +: 4], carry);
            addSum[i*4 +: 4] = s[3:0];
            carry            = s[4];
            if (i == N - 1) begin
                carryN = carry;
            end
        end
    end

    // Control FSM and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            opReg  <= OP_ADD;
            aReg   <= '0;
            bReg   <= '0;
            ciReg  <= 1'b0;
            errReg <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            o      <= '0;
            co     <= 1'b0;
            err    <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        aReg   <= a;
                        bReg   <= b;
                        ciReg  <= ci;
                        opReg  <= op_t'(op);
                        errReg <= inErr;
                        acc    <= '0;
                        cnt    <= CW'(N - 1);
                        state  <= (op_t'(op) == OP_MUL) ? ST_MUL : ST_ALU;
                    end
                end
                ST_ALU: begin
                    o     <= errReg ? '0 : {{W{1'b0}}, addSum[W-1:0]};
                    co    <= errReg ? 1'b0 : ((opReg == OP_SUB) ? ~carryN : carryN);
                    err   <= errReg;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                ST_MUL: begin
                    acc <= addSum;
                    if (cnt == '0) begin
                        o     <= errReg ? '0 : addSum;
                        co    <= 1'b0;
                        err   <= errReg;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_arith_seq.sv
// Directed self-checking bench for bcd_arith_seq with N=4.
module tb_bcd_arith_seq;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic        ci;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] o;
    logic        co;
    logic        err;
    logic        rdy;
    logic        done;

    int nCompared   = 0;
    int nMismatched = 0;

    bcd_arith_seq #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .ci    (ci),
        .a     (a),
        .b     (b),
        .o     (o),
        .co    (co),
        .err   (err),
        .rdy   (rdy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, scramble inputs after acceptance, and measure clocks until done (-1 on timeout).
    task automatic runOp(input logic [1:0] opV, input logic [15:0] aV, input logic [15:0] bV,
                         input logic ciV, output int lat);
        op = opV; a = aV; b = bV; ci = ciV; start = 1'b1;
        stepClk();
        start = 1'b0; op = 2'd2; a = 16'hFFFF; b = 16'hFFFF; ci = 1'b1;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            stepClk();
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        stepClk();
        stepClk();
        nCompared++; if (o !== 32'h0)  begin nMismatched++; $display("FAIL reset_o: got %h want %h", o, 32'h0); end
        nCompared++; if (co !== 1'b0)  begin nMismatched++; $display("FAIL reset_co: got %b want 0", co); end
        nCompared++; if (err !== 1'b0) begin nMismatched++; $display("FAIL reset_err: got %b want 0", err); end
        nCompared++; if (done !== 1'b0) begin nMismatched++; $display("FAIL reset_done: got %b want 0", done); end
        nCompared++; if (rdy !== 1'b1) begin nMismatched++; $display("FAIL reset_rdy: got %b want 1", rdy); end
        rst = 1'b0;
        stepClk();
    endtask

    task automatic test_add();
        int lat;
        runOp(2'd0, 16'h9999, 16'h0001, 1'b0, lat);
        nCompared++; if (lat != 1) begin nMismatched++; $display("FAIL add_wrap_lat: got %0d want 1", lat); end
        nCompared++; if (o !== 32'h00000000) begin nMismatched++; $display("FAIL add_wrap_o: got %h want 00000000", o); end
        nCompared++; if (co !== 1'b1) begin nMismatched++; $display("FAIL add_wrap_co: got %b want 1", co); end
        nCompared++; if (err !== 1'b0) begin nMismatched++; $display("FAIL add_wrap_err: got %b want 0", err); end
        runOp(2'd0, 16'h9999, 16'h0000, 1'b1, lat);
        nCompared++; if (o !== 32'h00000000) begin nMismatched++; $display("FAIL add_ci_o: got %h want 00000000", o); end
        nCompared++; if (co !== 1'b1) begin nMismatched++; $display("FAIL add_ci_co: got %b want 1", co); end
        runOp(2'd0, 16'h1234, 16'h5678, 1'b1, lat);
        nCompared++; if (o !== 32'h00006913) begin nMismatched++; $display("FAIL add_mid_o: got %h want 00006913", o); end
        nCompared++; if (co !== 1'b0) begin nMismatched++; $display("FAIL add_mid_co: got %b want 0", co); end
        runOp(2'd3, 16'h0045, 16'h0055, 1'b0, lat);
        nCompared++; if (lat != 1) begin nMismatched++; $display("FAIL rsvd_lat: got %0d want 1", lat); end
        nCompared++; if (o !== 32'h00000100) begin nMismatched++; $display("FAIL rsvd_o: got %h want 00000100", o); end
        nCompared++; if (err !== 1'b0) begin nMismatched++; $display("FAIL rsvd_err: got %b want 0", err); end
        stepClk();
        nCompared++; if (done !== 1'b0) begin nMismatched++; $display("FAIL done_pulse: got %b want 0", done); end
        nCompared++; if (o !== 32'h00000100) begin nMismatched++; $display("FAIL o_hold: got %h want 00000100", o); end
    endtask

    task automatic test_sub();
        int lat;
        runOp(2'd1, 16'h0005, 16'h0007, 1'b0, lat);
        nCompared++; if (lat != 1) begin nMismatched++; $display("FAIL sub_neg_lat: got %0d want 1", lat); end
        nCompared++; if (o !== 32'h00009998) begin nMismatched++; $display("FAIL sub_neg_o: got %h want 00009998", o); end
        nCompared++; if (co !== 1'b1) begin nMismatched++; $display("FAIL sub_neg_co: got %b want 1", co); end
        runOp(2'd1, 16'h1234, 16'h0234, 1'b0, lat);
        nCompared++; if (o !== 32'h00001000) begin nMismatched++; $display("FAIL sub_pos_o: got %h want 00001000", o); end
        nCompared++; if (co !== 1'b0) begin nMismatched++; $display("FAIL sub_pos_co: got %b want 0", co); end
        runOp(2'd1, 16'h1000, 16'h0999, 1'b1, lat);
        nCompared++; if (o !== 32'h00000000) begin nMismatched++; $display("FAIL sub_bi_o: got %h want 00000000", o); end
        nCompared++; if (co !== 1'b0) begin nMismatched++; $display("FAIL sub_bi_co: got %b want 0", co); end
    endtask

    task automatic test_mul();
        int lat;
        runOp(2'd2, 16'h1234, 16'h5678, 1'b1, lat);
        nCompared++; if (lat != 4) begin nMismatched++; $display("FAIL mul_lat: got %0d want 4", lat); end
        nCompared++; if (o !== 32'h07006652) begin nMismatched++; $display("FAIL mul_o: got %h want 07006652", o); end
        nCompared++; if (co !== 1'b0) begin nMismatched++; $display("FAIL mul_co: got %b want 0", co); end
        runOp(2'd2, 16'h9999, 16'h9999, 1'b0, lat);
        nCompared++; if (lat != 4) begin nMismatched++; $display("FAIL mul_max_lat: got %0d want 4", lat); end
        nCompared++; if (o !== 32'h99980001) begin nMismatched++; $display("FAIL mul_max_o: got %h want 99980001", o); end
        runOp(2'd2, 16'h1234, 16'h0000, 1'b0, lat);
        nCompared++; if (o !== 32'h00000000) begin nMismatched++; $display("FAIL mul_zero_o: got %h want 00000000", o); end
        runOp(2'd2, 16'h0010, 16'h0010, 1'b0, lat);
        nCompared++; if (o !== 32'h00000100) begin nMismatched++; $display("FAIL mul_shift_o: got %h want 00000100", o); end
    endtask

    task automatic test_back_to_back();
        int lat;
        int rdyLow;
        int doneCnt;
        rdyLow = 0; doneCnt = 0;
        op = 2'd2; a = 16'h1234; b = 16'h5678; ci = 1'b0; start = 1'b1;
        stepClk();
        // Keep requesting a different operation while the multiply runs.
        op = 2'd0; a = 16'h0001; b = 16'h0001;
        for (int i = 0; i < 4; i++) begin
            if (rdy === 1'b0) rdyLow++;
            stepClk();
            if (done === 1'b1) doneCnt++;
        end
        start = 1'b0;
        nCompared++; if (rdyLow != 4) begin nMismatched++; $display("FAIL hs_rdy_low: got %0d want 4", rdyLow); end
        nCompared++; if (doneCnt != 1) begin nMismatched++; $display("FAIL hs_done_cnt: got %0d want 1", doneCnt); end
        nCompared++; if (o !== 32'h07006652) begin nMismatched++; $display("FAIL hs_o: got %h want 07006652", o); end
        stepClk();
        nCompared++; if (done !== 1'b0) begin nMismatched++; $display("FAIL hs_no_extra_done: got %b want 0", done); end
        nCompared++; if (rdy !== 1'b1) begin nMismatched++; $display("FAIL hs_rdy_after: got %b want 1", rdy); end
        runOp(2'd0, 16'h0001, 16'h0001, 1'b0, lat);
        nCompared++; if (lat != 1) begin nMismatched++; $display("FAIL hs_next_lat: got %0d want 1", lat); end
        nCompared++; if (o !== 32'h00000002) begin nMismatched++; $display("FAIL hs_next_o: got %h want 00000002", o); end
    endtask

    task automatic test_err();
        int lat;
        runOp(2'd0, 16'h12A4, 16'h0001, 1'b0, lat);
        nCompared++; if (lat != 1) begin nMismatched++; $display("FAIL err_lat: got %0d want 1", lat); end
        nCompared++; if (err !== 1'b1) begin nMismatched++; $display("FAIL err_flag: got %b want 1", err); end
        nCompared++; if (o !== 32'h00000000) begin nMismatched++; $display("FAIL err_o: got %h want 00000000", o); end
        nCompared++; if (co !== 1'b0) begin nMismatched++; $display("FAIL err_co: got %b want 0", co); end
        runOp(2'd0, 16'h0001, 16'h0002, 1'b0, lat);
        nCompared++; if (err !== 1'b0) begin nMismatched++; $display("FAIL err_clear: got %b want 0", err); end
        nCompared++; if (o !== 32'h00000003) begin nMismatched++; $display("FAIL err_clear_o: got %h want 00000003", o); end
        runOp(2'd2, 16'h0002, 16'h00B3, 1'b0, lat);
        nCompared++; if (lat != 4) begin nMismatched++; $display("FAIL err_mul_lat: got %0d want 4", lat); end
        nCompared++; if (err !== 1'b1) begin nMismatched++; $display("FAIL err_mul_flag: got %b want 1", err); end
        nCompared++; if (o !== 32'h00000000) begin nMismatched++; $display("FAIL err_mul_o: got %h want 00000000", o); end
    endtask

    task automatic test_mid_reset();
        int lat;
        int doneSeen;
        // Leave a nonzero result behind so the reset clear is observable.
        runOp(2'd0, 16'h0004, 16'h0005, 1'b0, lat);
        op = 2'd2; a = 16'h1234; b = 16'h5678; ci = 1'b0; start = 1'b1;
        stepClk();
        start = 1'b0;
        stepClk();
        stepClk();
        rst = 1'b1;
        stepClk();
        nCompared++; if (done !== 1'b0) begin nMismatched++; $display("FAIL mrst_done: got %b want 0", done); end
        nCompared++; if (o !== 32'h00000000) begin nMismatched++; $display("FAIL mrst_o: got %h want 00000000", o); end
        nCompared++; if (rdy !== 1'b1) begin nMismatched++; $display("FAIL mrst_rdy: got %b want 1", rdy); end
        rst = 1'b0;
        doneSeen = 0;
        for (int i = 0; i < 5; i++) begin
            stepClk();
            if (done === 1'b1) doneSeen++;
        end
        nCompared++; if (doneSeen != 0) begin nMismatched++; $display("FAIL mrst_abort: got %0d done pulses want 0", doneSeen); end
        // Reset and start on the same edge: reset wins, nothing is launched.
        op = 2'd0; a = 16'h0001; b = 16'h0001; rst = 1'b1; start = 1'b1;
        stepClk();
        rst = 1'b0; start = 1'b0;
        doneSeen = 0;
        for (int i = 0; i < 3; i++) begin
            stepClk();
            if (done === 1'b1) doneSeen++;
        end
        nCompared++; if (doneSeen != 0) begin nMismatched++; $display("FAIL rst_prio: got %0d done pulses want 0", doneSeen); end
        runOp(2'd2, 16'h0002, 16'h0003, 1'b0, lat);
        nCompared++; if (lat != 4) begin nMismatched++; $display("FAIL mrst_mul_lat: got %0d want 4", lat); end
        nCompared++; if (o !== 32'h00000006) begin nMismatched++; $display("FAIL mrst_mul_o: got %h want 00000006", o); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'd0; ci = 1'b0; a = '0; b = '0;
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_back_to_back();
        test_err();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

endmodule
